wb_bram_ctrl: RTL and testbench

//  Wishbone classic slave that fronts the user-project block RAM. Decodes an

---
 rtl/wb_bram_pkg.sv | 15 +
 rtl/wb_bram_ctrl.sv | 119 +++++++++++
 tb/tb_wb_bram_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/wb_bram_pkg.sv
// Shared types and defaults for the Wishbone-to-BRAM bridge.
package wb_bram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    ACK
  } state_e;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h3800_0000;
  localparam int          DEF_WIN_BITS  = 22;
  localparam int          BYTE_SHIFT    = 2;

endpackage

// File: rtl/wb_bram_ctrl.sv
// Wishbone classic slave fronting a 1-cycle-latency BRAM,
// with a programmable wait inserted before each access.
module wb_bram_ctrl
  import wb_bram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          WIN_BITS  = DEF_WIN_BITS,
  parameter int          DELAYS    = 10,
  parameter int          CNT_W     = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_di,
  output logic [31:0] bram_a,
  input  logic [31:0] bram_do
);

  localparam logic [WIN_BITS-1:0] BASE_LO = BASE_ADDR[WIN_BITS-1:0];

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [WIN_BITS-1:0] adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;

  logic                hit;
  logic                req;
  logic [WIN_BITS-1:0] off;

  assign hit = wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS];
  assign req = wbs_cyc_i & wbs_stb_i & hit;
  // Offset wraps modulo the window size.
  assign off = adr_q - BASE_LO;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = wbs_we_i;
          sel_d   = wbs_sel_i;
          adr_d   = wbs_adr_i[WIN_BITS-1:0];
          dat_d   = wbs_dat_i;
          cnt_d   = CNT_W'(DELAYS);
          state_d = (DELAYS > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACCESS: state_d = ACK;
      ACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bram_en   = 1'b0;
    bram_we   = '0;
    bram_di   = '0;
    bram_a    = '0;
    wbs_ack_o = 1'b0;
    wbs_dat_o = '0;
    if (state_q == ACCESS) begin
      bram_en = 1'b1;
      bram_we = we_q ? sel_q : 4'b0000;
      bram_di = dat_q;
      bram_a  = 32'(off >> BYTE_SHIFT);
    end
    // Master dropping cyc in ACK silently ends the transfer.
    if (state_q == ACK && wbs_cyc_i) begin
      wbs_ack_o = 1'b1;
      wbs_dat_o = we_q ? 32'h0 : bram_do;
    end
  end

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Bench for wb_bram_ctrl: two instances (DELAYS=0 and 10)
// driven by directed and random transfers against a reference memory.
module tb_wb_bram_ctrl;

  localparam logic [31:0] BASE = 32'h3800_0000;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  logic [1:0]       cyc, stb, we_i, ack, en;
  logic [1:0][3:0]  sel, bwe;
  logic [1:0][31:0] adr, dat, dout, a, di, bdo;

  wb_bram_ctrl #(.DELAYS(0), .CNT_W(4)) u_dut0 (
    .CLK(CLK), .RSTn(RSTn),
    .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we_i[0]),
    .wbs_sel_i(sel[0]), .wbs_adr_i(adr[0]), .wbs_dat_i(dat[0]),
    .wbs_ack_o(ack[0]), .wbs_dat_o(dout[0]),
    .bram_en(en[0]), .bram_we(bwe[0]), .bram_di(di[0]),
    .bram_a(a[0]), .bram_do(bdo[0])
  );

  wb_bram_ctrl #(.DELAYS(10), .CNT_W(4)) u_dut1 (
    .CLK(CLK), .RSTn(RSTn),
    .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we_i[1]),
    .wbs_sel_i(sel[1]), .wbs_adr_i(adr[1]), .wbs_dat_i(dat[1]),
    .wbs_ack_o(ack[1]), .wbs_dat_o(dout[1]),
    .bram_en(en[1]), .bram_we(bwe[1]), .bram_di(di[1]),
    .bram_a(a[1]), .bram_do(bdo[1])
  );

  // BRAM stand-in: 256 words, 1-cycle read, output 0 when not enabled.
  logic [31:0] mem [2][256];
  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (en[k]) begin
        for (int b = 0; b < 4; b++)
          if (bwe[k][b]) mem[k][a[k][7:0]][8*b +: 8] <= di[k][8*b +: 8];
        bdo[k] <= mem[k][a[k][7:0]];
      end else begin
        bdo[k] <= '0;
      end
    end
  end

  logic [31:0] ref_mem [2][256];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input int k, input string tag, input bit en_e,
                         input logic [3:0] we_e, input logic [31:0] a_e,
                         input logic [31:0] di_e, input bit ack_e,
                         input logic [31:0] dat_e);
    chk({tag, ".en"}, 32'(en[k]), 32'(en_e));
    chk({tag, ".we"}, 32'(bwe[k]), 32'(we_e));
    chk({tag, ".a"}, a[k], a_e);
    chk({tag, ".di"}, di[k], di_e);
    chk({tag, ".ack"}, 32'(ack[k]), 32'(ack_e));
    chk({tag, ".dat"}, dout[k], dat_e);
  endtask

  function automatic int unsigned word_of(input logic [31:0] ad);
    return ((ad - BASE) % (32'd1 << 22)) / 4;
  endfunction

  // One transfer; drop>0 releases cyc in that cycle of the wait phase.
  task automatic xfer(input int k, input string tag, input bit w,
                      input logic [3:0] s, input logic [31:0] ad,
                      input logic [31:0] d, input int drop);
    bit hit, live, en_e, ack_e;
    int dly, n;
    int unsigned wi;
    logic [31:0] rd, nv;
    hit  = ad[31:22] == BASE[31:22];
    dly  = (k == 1) ? 10 : 0;
    live = hit && !(drop > 0 && drop <= dly);
    wi   = word_of(ad);
    rd   = ref_mem[k][wi % 256];
    n    = hit ? dly + 3 : 20;
    @(posedge CLK); #1;
    cyc[k] = 1; stb[k] = 1; we_i[k] = w;
    sel[k] = s; adr[k] = ad; dat[k] = d;
    for (int i = 1; i <= n; i++) begin
      @(posedge CLK);
      if (i == drop) begin
        #1; cyc[k] = 0; stb[k] = 0;
      end
      @(negedge CLK);
      en_e  = live && i == dly + 1;
      ack_e = live && i == dly + 2;
      chk_all(k, tag, en_e, (en_e && w) ? s : 4'h0,
              en_e ? 32'(wi) : 32'h0, en_e ? d : 32'h0,
              ack_e, (ack_e && !w) ? rd : 32'h0);
    end
    cyc[k] = 0; stb[k] = 0; we_i[k] = 0;
    sel[k] = 0; adr[k] = 0; dat[k] = 0;
    if (live && w) begin
      nv = rd;
      for (int b = 0; b < 4; b++)
        if (s[b]) nv[8*b +: 8] = d[8*b +: 8];
      ref_mem[k][wi % 256] = nv;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 256; j++) begin
        mem[k][j] = '0;
        ref_mem[k][j] = '0;
      end
    cyc = '0; stb = '0; we_i = '0; sel = '0; adr = '0; dat = '0;

    #12;
    chk_all(0, "reset0", 0, 0, 0, 0, 0, 0);
    chk_all(1, "reset1", 0, 0, 0, 0, 0, 0);
    #5 RSTn = 1'b1;

    xfer(1, "t1_wr", 1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF, 0);
    xfer(1, "t2_rd", 0, 4'hF, BASE + 32'h10, 32'h0, 0);
    xfer(1, "t3_wr", 1, 4'h1, BASE + 32'h10, 32'h0000_00AA, 0);
    xfer(1, "t3_rd", 0, 4'hF, BASE + 32'h10, 32'h0, 0);
    xfer(1, "t4_miss", 0, 4'hF, 32'h3000_0000, 32'h0, 0);
    xfer(1, "t4_hit", 0, 4'hF, BASE + 32'h10, 32'h0, 0);
    xfer(1, "t5_abort", 1, 4'hF, BASE + 32'h10, 32'h1234_5678, 5);
    xfer(1, "t5_rd", 0, 4'hF, BASE + 32'h10, 32'h0, 0);
    xfer(1, "sel0_wr", 1, 4'h0, BASE + 32'h20, 32'hFFFF_FFFF, 0);
    xfer(1, "sel0_rd", 0, 4'hF, BASE + 32'h20, 32'h0, 0);
    xfer(1, "wrap_wr", 1, 4'hF, BASE + 32'h3F_FFFC, 32'h5A5A_0FF0, 0);
    xfer(1, "wrap_rd", 0, 4'hF, BASE + 32'h3F_FFFC, 32'h0, 0);
    xfer(0, "d0_wr", 1, 4'h6, BASE + 32'h10, 32'h0BAD_CAFE, 0);
    xfer(0, "d0_rd", 0, 4'hF, BASE + 32'h10, 32'h0, 0);

    // Reset while the ack is up: outputs clear without a clock edge.
    @(posedge CLK); #1;
    cyc[1] = 1; stb[1] = 1; we_i[1] = 0; sel[1] = 4'hF;
    adr[1] = BASE + 32'h10;
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ack_pre", 32'(ack[1]), 32'h1);
    chk("rst_dat_pre", dout[1], ref_mem[1][4]);
    #2 RSTn = 1'b0;
    #1;
    chk_all(1, "rst_ack", 0, 0, 0, 0, 0, 0);
    cyc[1] = 0; stb[1] = 0; adr[1] = 0;
    #3 RSTn = 1'b1;

    // Reset in the middle of the wait: the write must never land.
    @(posedge CLK); #1;
    cyc[1] = 1; stb[1] = 1; we_i[1] = 1; sel[1] = 4'hF;
    adr[1] = BASE + 32'h40; dat[1] = 32'hCAFE_F00D;
    repeat (5) @(posedge CLK);
    #3 RSTn = 1'b0;
    #1;
    chk_all(1, "t6_rst", 0, 0, 0, 0, 0, 0);
    cyc[1] = 0; stb[1] = 0; we_i[1] = 0; sel[1] = 0;
    adr[1] = 0; dat[1] = 0;
    #3 RSTn = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      chk("t6_no_en", 32'(en[1]), 32'h0);
    end
    xfer(0, "t6_d0_rd", 0, 4'hF, BASE + 32'h10, 32'h0, 0);
    xfer(1, "t6_rd", 0, 4'hF, BASE + 32'h40, 32'h0, 0);

    for (int r = 0; r < 40; r++) begin
      int k;
      logic [31:0] ad;
      k  = int'($urandom_range(0, 1));
      ad = BASE + 32'($urandom_range(0, 31) << 2);
      if ($urandom_range(0, 7) == 0) ad = 32'h4000_0000 + ad[11:0];
      xfer(k, "rand", 1'($urandom_range(0, 1)), 4'($urandom),
           ad, $urandom, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
